// File: rtl/cdivider_seq.sv
// Sequential signed fixed-point complex divider Q = N / D.
// One restoring divider is shared: the real quotient is produced first, then the imaginary one.
module cdivider_seq #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   N_real,
  input  logic signed [DATA_W-1:0]   N_img,
  input  logic signed [DATA_W-1:0]   D_real,
  input  logic signed [DATA_W-1:0]   D_img,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [2*DATA_W-1:0] Q_real,
  output logic signed [2*DATA_W-1:0] Q_img,
  output logic                       div_zero
);

  localparam int P   = 2*DATA_W + 1;
  localparam int W_N = P + FRAC_W;
  localparam int CW  = $clog2(W_N);

  typedef enum logic [2:0] {IDLE, PREP, DIV_RE, DIV_IM, DONE} state_t;

  state_t                     state_q;
  logic signed [DATA_W-1:0]   nr_q, ni_q, dr_q, di_q;
  logic [P-1:0]               m_q;
  logic [P-1:0]               rem_q;
  logic [W_N-1:0]             num_q;
  logic [W_N-1:0]             mag_im_q;
  logic                       neg_re_q, neg_im_q;
  logic [CW-1:0]              cnt_q;
  logic                       in_ready_q, out_valid_q, dz_q;
  logic signed [2*DATA_W-1:0] q_re_q, q_im_q;

  logic signed [P-1:0]        nr_x, ni_x, dr_x, di_x;
  logic signed [P-1:0]        sum_re, sum_im, m_full;
  logic [P-1:0]               mag_re, mag_im;
  logic [P:0]                 trial;
  logic                       ge;
  logic [P-1:0]               rem_d;
  logic [2*DATA_W-1:0]        qt;
  logic                       last;

  // Operands widened before multiplying so every product and sum is exact.
  always_comb begin
    nr_x   = P'(nr_q);
    ni_x   = P'(ni_q);
    dr_x   = P'(dr_q);
    di_x   = P'(di_q);
    sum_re = nr_x * dr_x + ni_x * di_x;
    sum_im = ni_x * dr_x - nr_x * di_x;
    m_full = dr_x * dr_x + di_x * di_x;
    mag_re = sum_re[P-1] ? P'(-sum_re) : P'(sum_re);
    mag_im = sum_im[P-1] ? P'(-sum_im) : P'(sum_im);
  end

  // One restoring step: shift in the next dividend bit, subtract the divisor if it fits.
  always_comb begin
    trial = {rem_q, num_q[W_N-1]};
    ge    = (trial >= {1'b0, m_q});
    rem_d = ge ? (trial[P-1:0] - m_q) : trial[P-1:0];
    qt    = {num_q[2*DATA_W-2:0], ge};
    last  = (cnt_q == CW'(W_N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      nr_q        <= '0;
      ni_q        <= '0;
      dr_q        <= '0;
      di_q        <= '0;
      m_q         <= '0;
      rem_q       <= '0;
      num_q       <= '0;
      mag_im_q    <= '0;
      neg_re_q    <= 1'b0;
      neg_im_q    <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dz_q        <= 1'b0;
      q_re_q      <= '0;
      q_im_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            nr_q       <= N_real;
            ni_q       <= N_img;
            dr_q       <= D_real;
            di_q       <= D_img;
            dz_q       <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= PREP;
          end
        end
        PREP: begin
          m_q      <= m_full;
          neg_re_q <= sum_re[P-1];
          neg_im_q <= sum_im[P-1];
          num_q    <= W_N'(mag_re) << FRAC_W;
          mag_im_q <= W_N'(mag_im) << FRAC_W;
          rem_q    <= '0;
          cnt_q    <= '0;
          if (m_full == '0) begin
            dz_q    <= 1'b1;
            q_re_q  <= '0;
            q_im_q  <= '0;
            state_q <= DONE;
          end else begin
            state_q <= DIV_RE;
          end
        end
        DIV_RE: begin
          rem_q <= rem_d;
          num_q <= {num_q[W_N-2:0], ge};
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            q_re_q  <= neg_re_q ? -qt : qt;
            num_q   <= mag_im_q;
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= DIV_IM;
          end
        end
        DIV_IM: begin
          rem_q <= rem_d;
          num_q <= {num_q[W_N-2:0], ge};
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            q_im_q      <= neg_im_q ? -qt : qt;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // The zero-divisor path arrives with out_valid low and raises it one cycle later.
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Q_real    = q_re_q;
  assign Q_img     = q_im_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_cdivider_seq.sv
// Self-checking bench for cdivider_seq: directed vector table, handshake/reset sequences,
// and random operands checked against an integer-arithmetic reference.
module tb_cdivider_seq;
  localparam int DW  = 16;
  localparam int FW  = 8;
  localparam int LAT = 1 + 2*(2*DW + 1 + FW);

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic out_valid;
  logic out_ready = 1'b0;
  logic div_zero;
  logic signed [DW-1:0]   N_real = '0, N_img = '0, D_real = '0, D_img = '0;
  logic signed [2*DW-1:0] Q_real, Q_img;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cdivider_seq #(.DATA_W(DW), .FRAC_W(FW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .N_real(N_real), .N_img(N_img), .D_real(D_real), .D_img(D_img),
    .out_valid(out_valid), .out_ready(out_ready),
    .Q_real(Q_real), .Q_img(Q_img), .div_zero(div_zero)
  );

  typedef struct {
    int     nr, ni, dr, di;
    longint er, ei;
    int     edz;
    int     elat;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void model(input int nr, input int ni, input int dr, input int di,
                                output longint er, output longint ei,
                                output int dz, output int lat);
    longint re, im, m;
    re = longint'(nr) * dr + longint'(ni) * di;
    im = longint'(ni) * dr - longint'(nr) * di;
    m  = longint'(dr) * dr + longint'(di) * di;
    if (m == 0) begin
      er = 0; ei = 0; dz = 1; lat = 2;
    end else begin
      er = (re * (longint'(1) << FW)) / m;
      ei = (im * (longint'(1) << FW)) / m;
      dz = 0; lat = LAT;
    end
  endfunction

  // Precondition for all tasks: called just after a rising edge (#1).
  task automatic send(input int nr, input int ni, input int dr, input int di);
    int g = 0;
    while (!in_ready && g < 500) begin
      @(posedge clk); #1; g++;
    end
    chk("accept_ready", longint'(in_ready), 1);
    N_real = DW'(nr); N_img = DW'(ni); D_real = DW'(dr); D_img = DW'(di);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic handshake(input string nm, input bit keep);
    out_ready = 1'b1;
    @(posedge clk); #1;
    if (!keep) out_ready = 1'b0;
    chk({nm, ".ready_after"}, longint'(in_ready), 1);
    chk({nm, ".valid_after"}, longint'(out_valid), 0);
  endtask

  task automatic run_op(input string nm, input int nr, input int ni, input int dr, input int di,
                        input longint er, input longint ei, input int edz, input int elat,
                        input bit keep);
    int lat;
    send(nr, ni, dr, di);
    wait_out(lat);
    chk({nm, ".lat"}, lat, elat);
    chk({nm, ".re"}, longint'(Q_real), er);
    chk({nm, ".im"}, longint'(Q_img), ei);
    chk({nm, ".dz"}, longint'(div_zero), edz);
    handshake(nm, keep);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int     lat;
    longint er, ei;
    int     edz, elat;
    int     nr, ni, dr, di;

    tbl[0] = '{nr: 3,      ni: 4,      dr: 1,      di: 2,      er: 563,      ei: -102,     edz: 0, elat: LAT};
    tbl[1] = '{nr: -32768, ni: -32768, dr: 1,      di: 0,      er: -8388608, ei: -8388608, edz: 0, elat: LAT};
    tbl[2] = '{nr: 100,    ni: -7,     dr: 0,      di: 0,      er: 0,        ei: 0,        edz: 1, elat: 2};
    tbl[3] = '{nr: 1,      ni: 0,      dr: 1,      di: 0,      er: 256,      ei: 0,        edz: 0, elat: LAT};
    tbl[4] = '{nr: -32768, ni: -32768, dr: -32768, di: -32768, er: 256,      ei: 0,        edz: 0, elat: LAT};
    tbl[5] = '{nr: 7,      ni: -3,     dr: -2,     di: 5,      er: -256,     ei: -256,     edz: 0, elat: LAT};
    tbl[6] = '{nr: 5,      ni: 0,      dr: 2,      di: 0,      er: 640,      ei: 0,        edz: 0, elat: LAT};

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst.valid", longint'(out_valid), 0);
    chk("rst.re", longint'(Q_real), 0);
    chk("rst.im", longint'(Q_img), 0);
    chk("rst.dz", longint'(div_zero), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.ready", longint'(in_ready), 1);

    for (int i = 0; i < 7; i++)
      run_op($sformatf("tbl%0d", i), tbl[i].nr, tbl[i].ni, tbl[i].dr, tbl[i].di,
             tbl[i].er, tbl[i].ei, tbl[i].edz, tbl[i].elat, 1'b0);

    // Stall in DONE; an in_valid pulse with other operands must be ignored
    send(3, 4, 1, 2);
    wait_out(lat);
    chk("hold.lat", lat, LAT);
    for (int i = 0; i < 10; i++) begin
      chk("hold.valid", longint'(out_valid), 1);
      chk("hold.re", longint'(Q_real), 563);
      chk("hold.im", longint'(Q_img), -102);
      chk("hold.ready", longint'(in_ready), 0);
      if (i == 3) begin
        N_real = 16'sd9; N_img = 16'sd9; D_real = 16'sd1; D_img = 16'sd1;
        in_valid = 1'b1;
      end
      if (i == 5) in_valid = 1'b0;
      @(posedge clk); #1;
    end
    handshake("hold", 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("noacc.ready", longint'(in_ready), 1);
      chk("noacc.valid", longint'(out_valid), 0);
    end

    // Reset 20 cycles into the real-part division
    send(3, 4, 1, 2);
    repeat (21) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.valid", longint'(out_valid), 0);
    chk("midrst.re", longint'(Q_real), 0);
    chk("midrst.im", longint'(Q_img), 0);
    chk("midrst.dz", longint'(div_zero), 0);
    chk("midrst.ready", longint'(in_ready), 1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst.ready2", longint'(in_ready), 1);
    chk("midrst.valid2", longint'(out_valid), 0);
    run_op("post_rst", 5, 0, 2, 0, 640, 0, 0, LAT, 1'b0);

    // Back-to-back random operations with the consumer always ready
    out_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      nr = int'(DW'($urandom)) ;
      ni = int'(DW'($urandom));
      nr = (nr > 32767) ? nr - 65536 : nr;
      ni = (ni > 32767) ? ni - 65536 : ni;
      if ($urandom_range(0, 3) == 0) begin
        dr = int'($urandom_range(0, 4)) - 2;
        di = int'($urandom_range(0, 4)) - 2;
      end else begin
        dr = int'(DW'($urandom));
        di = int'(DW'($urandom));
        dr = (dr > 32767) ? dr - 65536 : dr;
        di = (di > 32767) ? di - 65536 : di;
      end
      model(nr, ni, dr, di, er, ei, edz, elat);
      run_op($sformatf("rnd%0d", k), nr, ni, dr, di, er, ei, edz, elat, 1'b1);
    end
    out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
